// File: rtl/keyed_dut_seq.sv
// Keyed XOR-fold compressor with a serial key loader and a precharge/evaluate query sequencer.
// Each query runs rep_n+1 PRE/EVAL pairs and then holds the result until out_ready.
module keyed_dut_seq #(
    parameter int unsigned IN_W  = 36,
    parameter int unsigned OUT_W = 7,
    parameter int unsigned KEY_W = 15,
    parameter int unsigned REP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_clr,
    input  logic             key_sen,
    input  logic             key_sin,
    output logic             key_valid,
    input  logic [REP_W-1:0] rep_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             eval_strobe,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] KEY_FULL = CNT_W'(KEY_W);

    typedef enum logic [1:0] {StIdle, StPre, StEval, StDone} state_t;

    state_t             state_q;
    logic [KEY_W-1:0]   key_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IN_W-1:0]    pat_q;
    logic [IN_W-1:0]    core_q;
    logic [REP_W-1:0]   rep_q;
    logic [OUT_W-1:0]   y;

    assign key_valid = (cnt_q == KEY_FULL);
    assign in_ready  = (state_q == StIdle) && key_valid;

    // Fold the keyed pattern: bit i lands on output bit i mod OUT_W.
    always_comb begin
        y = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            y[i % OUT_W] = y[i % OUT_W] ^ core_q[i] ^ key_q[i % KEY_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            key_q       <= '0;
            cnt_q       <= '0;
            pat_q       <= '0;
            core_q      <= '0;
            rep_q       <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            eval_strobe <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (key_clr) begin
                        key_q <= '0;
                        cnt_q <= '0;
                    end else if (key_sen) begin
                        key_q <= (key_q << 1) | KEY_W'(key_sin);
                        if (cnt_q != KEY_FULL) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    if (in_valid && key_valid) begin
                        pat_q   <= in_data;
                        rep_q   <= rep_n;
                        core_q  <= '0;
                        busy    <= 1'b1;
                        state_q <= StPre;
                    end
                end
                StPre: begin
                    core_q      <= pat_q;
                    eval_strobe <= 1'b1;
                    state_q     <= StEval;
                end
                StEval: begin
                    out_data    <= y;
                    eval_strobe <= 1'b0;
                    if (rep_q == '0) begin
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        rep_q   <= rep_q - 1'b1;
                        core_q  <= '0;
                        state_q <= StPre;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_keyed_dut_seq.sv
// Bench for keyed_dut_seq: directed scenarios plus random traffic, checked every cycle
// against a timeline-based reference model of the key loader and query sequencer.
module tb_keyed_dut_seq;

    localparam int IN_W = 36, OUT_W = 7, KEY_W = 15, REP_W = 8;

    logic             clk = 1'b0;
    logic             rst, key_clr, key_sen, key_sin, in_valid, out_ready;
    logic [REP_W-1:0] rep_n;
    logic [IN_W-1:0]  in_data;
    logic             key_valid, in_ready, out_valid, eval_strobe, busy;
    logic [OUT_W-1:0] out_data;

    keyed_dut_seq dut (
        .clk(clk), .rst(rst), .key_clr(key_clr), .key_sen(key_sen), .key_sin(key_sin),
        .key_valid(key_valid), .rep_n(rep_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .eval_strobe(eval_strobe), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] fold(input logic [IN_W-1:0] p,
                                              input logic [KEY_W-1:0] k);
        logic [OUT_W-1:0] r;
        for (int j = 0; j < OUT_W; j++) begin
            r[j] = 1'b0;
            for (int i = j; i < IN_W; i += OUT_W) r[j] = r[j] ^ p[i] ^ k[i % KEY_W];
        end
        return r;
    endfunction

    // Reference model: key state plus a query timeline counter c (c=0 is the first cycle
    // after acceptance; evaluates happen on odd c; result shows at c == 2*(rep+1)).
    logic [KEY_W-1:0] m_key = '0;
    int               m_cnt = 0;
    logic             m_busy = 1'b0;
    int               m_c = 0;
    int               m_end = 0;
    logic [OUT_W-1:0] m_y = '0;
    logic [OUT_W-1:0] m_out = '0;
    logic             cmp_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_key = '0; m_cnt = 0; m_busy = 1'b0; m_c = 0; m_out = '0;
        end else if (!m_busy) begin
            logic acc;
            acc = in_valid && (m_cnt == KEY_W);
            if (key_clr) begin
                m_key = '0; m_cnt = 0;
            end else if (key_sen) begin
                m_key = {m_key[KEY_W-2:0], key_sin};
                if (m_cnt < KEY_W) m_cnt++;
            end
            if (acc) begin
                m_busy = 1'b1; m_c = 0; m_end = 2 * (int'(rep_n) + 1);
                m_y = fold(in_data, m_key);
            end
        end else if (m_c == m_end) begin
            if (out_ready) m_busy = 1'b0;
        end else begin
            m_c++;
            if (m_c == 2) m_out = m_y;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("key_valid", key_valid, m_cnt == KEY_W);
            chk("in_ready", in_ready, !m_busy && m_cnt == KEY_W);
            chk("busy", busy, m_busy);
            chk("eval_strobe", eval_strobe, m_busy && m_c[0] && m_c < m_end);
            chk("out_valid", out_valid, m_busy && m_c == m_end);
            chk("out_data", out_data, m_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        key_clr = 0; key_sen = 0; key_sin = 0; in_valid = 0; out_ready = 0;
        rep_n = '0; in_data = '0;
    endtask

    task automatic load_key(input logic [KEY_W-1:0] k);
        for (int i = KEY_W - 1; i >= 0; i--) begin
            key_sen = 1; key_sin = k[i]; step();
        end
        key_sen = 0; key_sin = 0;
    endtask

    // Accept one query and wait (bounded) for out_valid; leaves the DUT in DONE.
    task automatic run_query(input logic [IN_W-1:0] d, input logic [REP_W-1:0] r,
                             output int lat, output int strobes, output logic [OUT_W-1:0] od);
        in_data = d; rep_n = r; in_valid = 1; step();
        in_valid = 0; in_data = '0; rep_n = '0;
        lat = 0; strobes = 0;
        while (!out_valid && lat < 600) begin
            if (eval_strobe) strobes++;
            step(); lat++;
        end
        od = out_data;
    endtask

    task automatic release_out();
        out_ready = 1; step(); out_ready = 0;
    endtask

    int lat, strb;
    logic [OUT_W-1:0] od, held;

    initial begin
        quiet();
        rst = 1; step(); step();
        chk("rst key_valid", key_valid, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst eval_strobe", eval_strobe, 0);
        chk("rst busy", busy, 0);
        rst = 0;
        cmp_en = 1;

        // Key loads with ones: valid only after the 15th shift.
        key_sen = 1; key_sin = 1;
        for (int i = 0; i < KEY_W - 1; i++) step();
        chk("key_valid after 14", key_valid, 0);
        step();
        chk("key_valid after 15", key_valid, 1);
        chk("model key 7fff", m_key, 15'h7FFF);

        // Clear wins over shift.
        key_clr = 1; key_sen = 1; key_sin = 1; step();
        key_clr = 0; key_sen = 0;
        chk("clr+sen key_valid", key_valid, 0);
        chk("clr+sen model cnt", m_cnt, 0);

        load_key('0);
        run_query(36'h1, 0, lat, strb, od);
        chk("q0 latency", lat, 2);
        chk("q0 strobes", strb, 1);
        chk("q0 out_data", od, 7'h01);
        release_out();

        // All-ones key, zero data: 36 bits fold 6/5/5/5/5/5/5 ones onto bits 0..6.
        load_key(15'h7FFF);
        run_query('0, 3, lat, strb, od);
        chk("q1 latency", lat, 8);
        chk("q1 strobes", strb, 4);
        chk("q1 out_data", od, 7'h7E);

        // Stall in DONE with key traffic and a pending request.
        held = out_data;
        key_sen = 1; key_clr = 1; in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            key_clr = i[0];
            step();
            chk("stall out_data", out_data, held);
            chk("stall in_ready", in_ready, 0);
            chk("stall out_valid", out_valid, 1);
        end
        key_sen = 0; key_clr = 0; in_valid = 0;
        release_out();
        chk("key kept", key_valid, 1);
        run_query('0, 0, lat, strb, od);
        chk("q2 out_data", od, 7'h7E);
        release_out();

        run_query(36'h9_8765_4321, 8'hFF, lat, strb, od);
        chk("max rep latency", lat, 512);
        chk("max rep strobes", strb, 256);
        chk("max rep out_data", od, fold(36'h9_8765_4321, 15'h7FFF));
        release_out();

        // Reset during EVAL aborts the query.
        in_data = 36'hF_0000_000F; rep_n = 2; in_valid = 1; step();
        in_valid = 0; step();
        chk("in eval", eval_strobe, 1);
        rst = 1; step(); rst = 0;
        chk("abort busy", busy, 0);
        chk("abort key_valid", key_valid, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort no out_valid", out_valid, 0);
        end

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            key_clr   = ($urandom_range(0, 79) == 0);
            key_sen   = $urandom_range(0, 1);
            key_sin   = $urandom_range(0, 1);
            in_valid  = $urandom_range(0, 2) == 0;
            in_data   = {$urandom_range(0, 15), $urandom()};
            rep_n     = REP_W'($urandom_range(0, 4));
            out_ready = $urandom_range(0, 2) != 0;
            step();
        end
        quiet(); rst = 0;
        step(); step();
        cmp_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
